// File: rtl/arcanoid_game_ctl.sv
// Arkanoid game sequencer: serve/hold control, lives, level, score
// and per-level block map reload, paced by vsync frame ticks.
module arcanoid_game_ctl #(
  parameter int NUM_BLOCKS   = 16,
  parameter int LIVES_INIT   = 3,
  parameter int PAUSE_FRAMES = 60,
  parameter int FLOOR_Y      = 760
) (
  input  logic                  pclk,
  input  logic                  reset,
  input  logic                  vsync_in,
  input  logic                  mouse_left,
  input  logic [11:0]           ball_y,
  input  logic [NUM_BLOCKS-1:0] blocks_in,
  output logic                  ball_hold,
  output logic                  serve,
  output logic                  blocks_load,
  output logic [NUM_BLOCKS-1:0] blocks_init,
  output logic [1:0]            lives,
  output logic [1:0]            level,
  output logic [15:0]           score,
  output logic [2:0]            game_state
);

  localparam int CW = $clog2(PAUSE_FRAMES + 1);
  localparam int AW = $clog2(NUM_BLOCKS + 1);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_LOAD  = 3'd1,
    S_READY = 3'd2,
    S_PLAY  = 3'd3,
    S_LOST  = 3'd4,
    S_CLEAR = 3'd5,
    S_OVER  = 3'd6
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            lives_q, lives_d;
  logic [1:0]            level_q, level_d;
  logic [15:0]           score_q, score_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  serve_q, serve_d;
  logic                  load_q, load_d;
  logic                  s1_q, s2_q, s3_q;
  logic                  vs_q;
  logic [NUM_BLOCKS-1:0] prev_q;

  logic                  click;
  logic                  tick;
  logic [NUM_BLOCKS-1:0] gone;
  logic [AW-1:0]         addend;
  logic [16:0]           sum;

  assign click = s2_q & ~s3_q;
  assign tick  = vsync_in & ~vs_q;
  assign gone  = prev_q & ~blocks_in;

  always_comb begin
    addend = '0;
    for (int i = 0; i < NUM_BLOCKS; i++)
      addend = addend + AW'(gone[i]);
  end

  assign sum = {1'b0, score_q} + 17'(addend);

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    level_d = level_q;
    score_d = score_q;
    cnt_d   = cnt_q;
    serve_d = 1'b0;
    if (state_q == S_PLAY)
      score_d = sum[16] ? 16'hFFFF : sum[15:0];
    unique case (state_q)
      S_BOOT:  state_d = S_LOAD;
      S_LOAD:  state_d = S_READY;
      S_READY: begin
        if (click) begin
          state_d = S_PLAY;
          serve_d = 1'b1;
        end
      end
      S_PLAY: begin
        // A cleared board beats a simultaneous floor hit
        if (blocks_in == '0) begin
          state_d = S_CLEAR;
          level_d = level_q + 2'd1;
          cnt_d   = '0;
        end else if (ball_y >= 12'(FLOOR_Y)) begin
          state_d = S_LOST;
          lives_d = lives_q - 2'd1;
          cnt_d   = '0;
        end
      end
      S_LOST: begin
        if (lives_q == 2'd0) begin
          state_d = S_OVER;
        end else if (tick) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CW'(PAUSE_FRAMES))
            state_d = S_READY;
        end
      end
      S_CLEAR: begin
        if (tick) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == CW'(PAUSE_FRAMES))
            state_d = S_LOAD;
        end
      end
      S_OVER: begin
        if (click) begin
          lives_d = 2'(LIVES_INIT);
          level_d = 2'd0;
          score_d = 16'd0;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_BOOT;
    endcase
    load_d = (state_d == S_LOAD);
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      state_q <= S_BOOT;
      lives_q <= 2'(LIVES_INIT);
      level_q <= 2'd0;
      score_q <= 16'd0;
      cnt_q   <= '0;
      serve_q <= 1'b0;
      load_q  <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      vs_q    <= 1'b0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      level_q <= level_d;
      score_q <= score_d;
      cnt_q   <= cnt_d;
      serve_q <= serve_d;
      load_q  <= load_d;
      s1_q    <= mouse_left;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      vs_q    <= vsync_in;
      prev_q  <= blocks_in;
    end
  end

  always_comb begin
    blocks_init = '0;
    unique case (level_q)
      2'd0: blocks_init = NUM_BLOCKS'(16'hFFFF);
      2'd1: blocks_init = NUM_BLOCKS'(16'h5A5A);
      2'd2: blocks_init = NUM_BLOCKS'(16'h0FF0);
      2'd3: blocks_init = NUM_BLOCKS'(16'hFFFF);
      default: blocks_init = '0;
    endcase
  end

  assign ball_hold   = (state_q != S_PLAY);
  assign serve       = serve_q;
  assign blocks_load = load_q;
  assign lives       = lives_q;
  assign level       = level_q;
  assign score       = score_q;
  assign game_state  = state_q;

endmodule
